alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state issue controller driving an external 8-bit ALU
// Owns R0..R3 and the architectural flags; one instruction in flight at a time.
module alu_issue_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_res,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    output logic [3:0]  flags,
    output logic [7:0]  show_data,
    output logic        show_valid,
    output logic        illegal
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LDI   = 4'b0010;
    localparam logic [3:0] OP_SHOWR = 4'b1111;

    state_t      state_q;
    logic        ready_q;
    logic [15:0] instr_q;
    logic [7:0]  regs_q [4];
    logic [3:0]  flags_q;
    logic [7:0]  alu_in1_q;
    logic [7:0]  alu_in2_q;
    logic [3:0]  alu_op_q;
    logic [7:0]  show_data_q;
    logic        show_valid_q;
    logic        illegal_q;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       op_known;

    assign op       = instr_q[15:12];
    assign rd       = instr_q[11:10];
    assign rs       = instr_q[9:8];
    assign imm      = instr_q[7:0];
    assign op_known = (op == OP_NOP) || (op == OP_ADD) || (op == OP_LDI) || (op == OP_SHOWR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            instr_q      <= 16'h0000;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
            flags_q      <= 4'b0000;
            alu_in1_q    <= 8'h00;
            alu_in2_q    <= 8'h00;
            alu_op_q     <= OP_NOP;
            show_data_q  <= 8'h00;
            show_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            show_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid && ready_q) begin
                        instr_q <= instr;
                        ready_q <= 1'b0;
                        state_q <= S_DECODE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    // Operands are snapshotted here, so ADD rd,rd sees the pre-write value twice.
                    alu_in1_q <= regs_q[rd];
                    alu_in2_q <= (op == OP_LDI) ? imm : regs_q[rs];
                    alu_op_q  <= op;
                    state_q   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    illegal_q <= !op_known;
                    state_q   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    case (op)
                        OP_ADD: begin
                            regs_q[rd] <= alu_res;
                            flags_q    <= {alu_cf, alu_zf, alu_sf, alu_of};
                        end
                        OP_LDI:   regs_q[rd] <= imm;
                        OP_SHOWR: begin
                            show_data_q  <= regs_q[rd];
                            show_valid_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    alu_op_q <= OP_NOP;
                    ready_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = ready_q && !reset;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_op      = alu_op_q;
    assign flags       = flags_q;
    assign show_data   = show_data_q;
    assign show_valid  = show_valid_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
// A behavioural ALU drives the DUT's ALU inputs; a register-level model predicts results.
module tb_alu_issue_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_in1, alu_in2, alu_res;
    logic [3:0]  alu_op, flags;
    logic        alu_cf, alu_zf, alu_sf, alu_of;
    logic [7:0]  show_data;
    logic        show_valid, illegal;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] m_r [4];
    logic [3:0] m_flags;
    logic [7:0] m_show;
    logic       e_illegal, e_show_valid;

    logic       obs_ready_dec, obs_illegal_wb, obs_illegal_next, obs_show_valid, obs_sv_next, obs_ready_idle;
    logic [3:0] obs_alu_op_ex, obs_alu_op_idle, obs_flags;
    logic [7:0] obs_show_data;

    alu_issue_ctrl dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .flags(flags), .show_data(show_data), .show_valid(show_valid), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Downstream ALU: only ADD produces real flags; everything else reports all-ones.
    always_comb begin
        logic [8:0] s9;
        s9      = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_res = 8'h00;
        alu_cf  = 1'b1;
        alu_zf  = 1'b1;
        alu_sf  = 1'b1;
        alu_of  = 1'b1;
        if (alu_op == 4'b0001) begin
            alu_res = s9[7:0];
            alu_cf  = s9[8];
            alu_zf  = (s9[7:0] == 8'h00);
            alu_sf  = s9[7];
            alu_of  = (alu_in1[7] == alu_in2[7]) && (s9[7] != alu_in1[7]);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_flags = 4'b0000;
        m_show  = 8'h00;
    endtask

    task automatic model_step(input logic [15:0] ins);
        int a, b, s, r, sa, sb, ss;
        logic [3:0] op;
        op = ins[15:12];
        e_illegal    = !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hF);
        e_show_valid = (op == 4'hF);
        if (op == 4'h1) begin
            a  = int'(m_r[ins[11:10]]);
            b  = int'(m_r[ins[9:8]]);
            s  = a + b;
            r  = s % 256;
            sa = (a > 127) ? a - 256 : a;
            sb = (b > 127) ? b - 256 : b;
            ss = sa + sb;
            m_flags = {(s > 255), (r == 0), (r > 127), (ss > 127 || ss < -128)};
            m_r[ins[11:10]] = 8'(r);
        end else if (op == 4'h2) begin
            m_r[ins[11:10]] = ins[7:0];
        end else if (op == 4'hF) begin
            m_show = m_r[ins[11:10]];
        end
    endtask

    // Drives one instruction through all four states and records what the DUT shows.
    task automatic issue(input logic [15:0] ins, input bit noise);
        int guard = 0;
        while (!instr_ready && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_wait_ready got %b want 1", instr_ready);
        end
        instr = ins;
        instr_valid = 1'b1;
        tick();
        obs_ready_dec = instr_ready;
        if (noise) begin instr = 16'($urandom); instr_valid = 1'($urandom); end else instr_valid = 1'b0;
        tick();
        obs_alu_op_ex = alu_op;
        if (noise) begin instr = 16'($urandom); instr_valid = 1'($urandom); end
        tick();
        obs_illegal_wb = illegal;
        if (noise) begin instr = 16'($urandom); instr_valid = 1'($urandom); end
        tick();
        instr_valid     = 1'b0;
        obs_ready_idle  = instr_ready;
        obs_show_valid  = show_valid;
        obs_show_data   = show_data;
        obs_flags       = flags;
        obs_alu_op_idle = alu_op;
        obs_illegal_next = illegal;
        tick();
        obs_sv_next = show_valid;
        model_step(ins);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b1;
        instr = 16'h1600;
        tick();
        tick();
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_during got %b want 0", instr_ready); end
        n_checks++; if ({flags, alu_op} !== 8'h00) begin n_fail++; $display("FAIL rst_flags_op got %h want 00", {flags, alu_op}); end
        n_checks++; if ({alu_in1, alu_in2, show_data} !== 24'h0) begin n_fail++; $display("FAIL rst_data got %h want 000000", {alu_in1, alu_in2, show_data}); end
        n_checks++; if ({show_valid, illegal} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {show_valid, illegal}); end
        instr_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", instr_ready); end
        // Reset arriving together with a valid instruction must win.
        instr_valid = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_comb got %b want 0", instr_ready); end
        tick();
        instr_valid = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if ({instr_ready, alu_op} !== 5'b1_0000) begin n_fail++; $display("FAIL rst_priority got %b want 10000", {instr_ready, alu_op}); end
        model_reset();
    endtask

    task automatic test_directed();
        issue(16'h247F, 0);
        issue(16'h2801, 0);
        issue(16'h1600, 0);
        n_checks++; if (obs_flags !== 4'b0011) begin n_fail++; $display("FAIL add_7f_flags got %b want 0011", obs_flags); end
        n_checks++; if (obs_alu_op_ex !== 4'b0001) begin n_fail++; $display("FAIL add_alu_op got %b want 0001", obs_alu_op_ex); end
        issue(16'hF400, 0);
        n_checks++; if (obs_show_data !== 8'h80) begin n_fail++; $display("FAIL show_r1 got %h want 80", obs_show_data); end
        n_checks++; if ({obs_show_valid, obs_sv_next} !== 2'b10) begin n_fail++; $display("FAIL show_strobe got %b want 10", {obs_show_valid, obs_sv_next}); end
        n_checks++; if (obs_flags !== 4'b0011) begin n_fail++; $display("FAIL show_flags got %b want 0011", obs_flags); end
        issue(16'h2C55, 0);
        issue(16'h0000, 0);
        n_checks++; if (obs_flags !== 4'b0011) begin n_fail++; $display("FAIL ldi_nop_flags got %b want 0011", obs_flags); end
        n_checks++; if (obs_show_data !== 8'h80) begin n_fail++; $display("FAIL show_hold got %h want 80", obs_show_data); end
        issue(16'h20FF, 0);
        issue(16'h2C01, 0);
        issue(16'h1300, 0);
        n_checks++; if (obs_flags !== 4'b1100) begin n_fail++; $display("FAIL add_ff_flags got %b want 1100", obs_flags); end
        issue(16'hF000, 0);
        n_checks++; if (obs_show_data !== 8'h00) begin n_fail++; $display("FAIL add_ff_r0 got %h want 00", obs_show_data); end
        issue(16'h2440, 0);
        issue(16'h1500, 0);
        issue(16'hF400, 0);
        n_checks++; if (obs_show_data !== 8'h80) begin n_fail++; $display("FAIL add_rd_eq_rs got %h want 80", obs_show_data); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] pat;
        issue({4'h2, 2'd1, 2'd0, 8'($urandom)}, 0);
        issue({4'h2, 2'd2, 2'd0, 8'($urandom)}, 0);
        instr = 16'h1600;
        instr_valid = 1'b1;
        pat[4] = instr_ready;
        for (int i = 3; i >= 0; i--) begin
            tick();
            pat[i] = instr_ready;
        end
        instr_valid = 1'b0;
        model_step(16'h1600);
        n_checks++; if (pat !== 5'b10001) begin n_fail++; $display("FAIL b2b_ready_pattern got %b want 10001", pat); end
        tick();
        issue(16'hF400, 0);
        n_checks++; if (obs_show_data !== m_r[1]) begin n_fail++; $display("FAIL b2b_single_exec got %h want %h", obs_show_data, m_r[1]); end
    endtask

    task automatic test_reset_mid();
        issue(16'h2411, 0);
        issue(16'h2822, 0);
        issue(16'h1600, 0);
        instr = 16'h1600;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset got %b want 0", instr_ready); end
        reset = 1'b0;
        tick();
        model_reset();
        n_checks++; if ({instr_ready, flags, alu_op} !== 9'b1_0000_0000) begin n_fail++; $display("FAIL mid_state got %b want 100000000", {instr_ready, flags, alu_op}); end
        tick();
        tick();
        tick();
        n_checks++; if ({flags, show_valid, illegal} !== 6'b0) begin n_fail++; $display("FAIL mid_no_write got %b want 000000", {flags, show_valid, illegal}); end
        for (int r = 0; r < 4; r++) begin
            issue({4'hF, 2'(r), 10'h0}, 0);
            n_checks++; if (obs_show_data !== 8'h00) begin n_fail++; $display("FAIL mid_reg%0d got %h want 00", r, obs_show_data); end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] f0;
        issue(16'h2D9C, 0);
        issue(16'h1700, 0);
        f0 = m_flags;
        issue({4'b0101, 12'($urandom)}, 0);
        n_checks++; if ({obs_illegal_wb, obs_illegal_next} !== 2'b10) begin n_fail++; $display("FAIL ill_strobe got %b want 10", {obs_illegal_wb, obs_illegal_next}); end
        n_checks++; if (obs_flags !== f0) begin n_fail++; $display("FAIL ill_flags got %b want %b", obs_flags, f0); end
        for (int r = 0; r < 4; r++) begin
            issue({4'hF, 2'(r), 10'h0}, 0);
            n_checks++; if (obs_show_data !== m_r[r]) begin n_fail++; $display("FAIL ill_reg%0d got %h want %h", r, obs_show_data, m_r[r]); end
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [6];
        logic [15:0] ins;
        ops = '{4'h0, 4'h1, 4'h1, 4'h2, 4'hF, 4'h9};
        for (int n = 0; n < 80; n++) begin
            ins = {ops[$urandom_range(5)], 12'($urandom)};
            if (ins[15:12] == 4'h9) ins[15:12] = 4'($urandom_range(3, 14));
            issue(ins, 1);
            n_checks++; if (obs_alu_op_ex !== ins[15:12]) begin n_fail++; $display("FAIL rnd%0d_alu_op got %h want %h", n, obs_alu_op_ex, ins[15:12]); end
            n_checks++; if ({obs_illegal_wb, obs_illegal_next} !== {e_illegal, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_illegal got %b want %b0", n, {obs_illegal_wb, obs_illegal_next}, e_illegal); end
            n_checks++; if ({obs_show_valid, obs_sv_next} !== {e_show_valid, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_show_valid got %b want %b0", n, {obs_show_valid, obs_sv_next}, e_show_valid); end
            n_checks++; if (obs_show_data !== m_show) begin n_fail++; $display("FAIL rnd%0d_show_data got %h want %h", n, obs_show_data, m_show); end
            n_checks++; if (obs_flags !== m_flags) begin n_fail++; $display("FAIL rnd%0d_flags got %b want %b", n, obs_flags, m_flags); end
            n_checks++; if ({obs_ready_dec, obs_ready_idle, obs_alu_op_idle} !== 6'b01_0000) begin n_fail++; $display("FAIL rnd%0d_ready_op got %b want 010000", n, {obs_ready_dec, obs_ready_idle, obs_alu_op_idle}); end
        end
        for (int r = 0; r < 4; r++) begin
            issue({4'hF, 2'(r), 10'h0}, 0);
            n_checks++; if (obs_show_data !== m_r[r]) begin n_fail++; $display("FAIL rnd_final_reg%0d got %h want %h", r, obs_show_data, m_r[r]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
